// File: rtl/gamma_dec_issue.sv
// gamma_dec_issue: decode-to-execute issue stage.
// Holds the architectural register file and a pending-write scoreboard, stalls
// on RAW/WAW hazards, optionally forwards same-cycle writeback data, and
// registers the selected operands toward execute.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Input side: fire = in_valid_i & in_ready_o; in_ready_o may depend
// combinationally on the in_* fields. Output side: out_* hold steady while
// out_valid_o & ~out_ready_i; a transfer happens on out_valid_o & out_ready_i.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   in_*      decoded instruction from decoder (valid/ready)
//   wb_*      writeback strobe/index/data from execute
//   flush_i   kill instruction held in the output register
//   out_*     registered issue packet toward execute (valid/ready)
//   busy_o    output valid or any register write pending
module gamma_dec_issue #(
  parameter int DataWidth = 32,
  parameter int Embedded  = 0,
  parameter int Bypass    = 1,
  parameter int CtrlWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4:0]           in_rs1_i,
  input  logic [4:0]           in_rs2_i,
  input  logic [4:0]           in_rd_i,
  input  logic                 in_rd_we_i,
  input  logic [1:0]           in_src1_sel_i,
  input  logic [1:0]           in_src2_sel_i,
  input  logic [DataWidth-1:0] in_imm_i,
  input  logic [DataWidth-1:0] in_pc_i,
  input  logic [CtrlWidth-1:0] in_ctrl_i,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_rd_i,
  input  logic [DataWidth-1:0] wb_data_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_operand_a_o,
  output logic [DataWidth-1:0] out_operand_b_o,
  output logic [DataWidth-1:0] out_imm_o,
  output logic [DataWidth-1:0] out_pc_o,
  output logic [4:0]           out_rd_o,
  output logic                 out_rd_we_o,
  output logic [CtrlWidth-1:0] out_ctrl_o,
  output logic                 out_illegal_o,
  output logic                 busy_o
);

  localparam int NumRegs = (Embedded != 0) ? 16 : 32;
  localparam int IdxW    = (Embedded != 0) ? 4 : 5;
  localparam logic BypassEn = (Bypass != 0);

  function automatic logic legal(input logic [4:0] idx);
    return {1'b0, idx} < 6'(NumRegs);
  endfunction

  logic [DataWidth-1:0] rf [NumRegs];
  logic [NumRegs-1:0]   pending;
  logic [NumRegs-1:0]   pending_nxt;

  logic rs1_used, rs2_used, rs1_legal, rs2_legal, rd_legal, illegal;
  logic clr1, clr2, clrd, busy1, busy2, busyd, hazard, fire;
  logic wb_we, sb_set, flush_clr;
  logic [DataWidth-1:0] rs1_val, rs2_val, op_a, op_b;

  assign rs1_used  = (in_src1_sel_i == 2'b00);
  assign rs2_used  = (in_src2_sel_i == 2'b00);
  assign rs1_legal = legal(in_rs1_i);
  assign rs2_legal = legal(in_rs2_i);
  assign rd_legal  = legal(in_rd_i);
  assign illegal   = (rs1_used & ~rs1_legal) | (rs2_used & ~rs2_legal) |
                     (in_rd_we_i & ~rd_legal);

  assign clr1 = wb_valid_i & (wb_rd_i == in_rs1_i);
  assign clr2 = wb_valid_i & (wb_rd_i == in_rs2_i);
  assign clrd = wb_valid_i & (wb_rd_i == in_rd_i);

  // Out-of-range indices never stall; they are flagged as illegal instead.
  assign busy1 = rs1_legal & pending[in_rs1_i[IdxW-1:0]] & ~(BypassEn & clr1);
  assign busy2 = rs2_legal & pending[in_rs2_i[IdxW-1:0]] & ~(BypassEn & clr2);
  // A WAW retiring this cycle is resolved regardless of forwarding: the old
  // writer is done, and the new pending bit wins over the clear.
  assign busyd = rd_legal & pending[in_rd_i[IdxW-1:0]] & ~clrd;

  assign hazard     = (rs1_used & busy1) | (rs2_used & busy2) | (in_rd_we_i & busyd);
  assign in_ready_o = (~out_valid_o | out_ready_i) & ~hazard & ~flush_i;
  assign fire       = in_valid_i & in_ready_o;

  assign wb_we     = wb_valid_i & (wb_rd_i != 5'd0) & legal(wb_rd_i);
  assign sb_set    = fire & in_rd_we_i & (in_rd_i != 5'd0) & ~illegal;
  // A killed writer never reaches writeback, so its pending bit is dropped.
  assign flush_clr = flush_i & out_valid_o & out_rd_we_o & ~out_ready_i &
                     ~out_illegal_o & (out_rd_o != 5'd0);

  always_comb begin
    rs1_val = '0;
    if (rs1_legal && in_rs1_i != 5'd0) begin
      if (BypassEn && clr1) rs1_val = wb_data_i;
      else                  rs1_val = rf[in_rs1_i[IdxW-1:0]];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_legal && in_rs2_i != 5'd0) begin
      if (BypassEn && clr2) rs2_val = wb_data_i;
      else                  rs2_val = rf[in_rs2_i[IdxW-1:0]];
    end
  end

  always_comb begin
    op_a = '0;
    case (in_src1_sel_i)
      2'b00:   op_a = rs1_val;
      2'b01:   op_a = in_imm_i;
      2'b10:   op_a = in_pc_i;
      default: op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    case (in_src2_sel_i)
      2'b00:   op_b = rs2_val;
      2'b01:   op_b = in_imm_i;
      2'b10:   op_b = DataWidth'(4);
      default: op_b = '0;
    endcase
  end

  // Set is applied last so it wins over a same-cycle clear of the same entry.
  always_comb begin
    pending_nxt = pending;
    if (wb_we)     pending_nxt[wb_rd_i[IdxW-1:0]]  = 1'b0;
    if (flush_clr) pending_nxt[out_rd_o[IdxW-1:0]] = 1'b0;
    if (sb_set)    pending_nxt[in_rd_i[IdxW-1:0]]  = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) rf[i] <= '0;
      pending <= '0;
    end else begin
      if (wb_we) rf[wb_rd_i[IdxW-1:0]] <= wb_data_i;
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o     <= 1'b0;
      out_operand_a_o <= '0;
      out_operand_b_o <= '0;
      out_imm_o       <= '0;
      out_pc_o        <= '0;
      out_rd_o        <= '0;
      out_rd_we_o     <= 1'b0;
      out_ctrl_o      <= '0;
      out_illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (fire) begin
      out_valid_o     <= 1'b1;
      out_operand_a_o <= op_a;
      out_operand_b_o <= op_b;
      out_imm_o       <= in_imm_i;
      out_pc_o        <= in_pc_i;
      out_rd_o        <= in_rd_i;
      out_rd_we_o     <= in_rd_we_i;
      out_ctrl_o      <= in_ctrl_i;
      out_illegal_o   <= illegal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign busy_o = out_valid_o | (|pending);

endmodule

// File: tb/tb_gamma_dec_issue.sv
// Bench for gamma_dec_issue: main instance is RV32E with forwarding; a second
// instance (32 regs, no forwarding) covers the non-bypass RAW/WAW timing.
module tb_gamma_dec_issue;

  localparam int EW = 71; // {op_a, op_b, rd, rd_we, illegal}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, z_in_valid = 1'b0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rd_we = 1'b0;
  logic [1:0]  in_s1 = '0, in_s2 = '0;
  logic [31:0] in_imm = '0, in_pc = '0, in_ctrl = '0;
  logic        wb_valid = 1'b0, z_wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_rd_we, out_illegal, busy;
  logic [31:0] out_a, out_b, out_imm, out_pc, out_ctrl;
  logic [4:0]  out_rd;
  logic        z_in_ready, z_out_valid, z_out_rd_we, z_out_illegal, z_busy;
  logic [31:0] z_out_a, z_out_b, z_out_imm, z_out_pc, z_out_ctrl;
  logic [4:0]  z_out_rd;

  logic [EW-1:0] exp_q[$];
  int total_cnt = 0;
  int bad_cnt = 0;
  int waits;

  gamma_dec_issue #(.DataWidth(32), .Embedded(1), .Bypass(1), .CtrlWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd), .in_rd_we_i(in_rd_we),
    .in_src1_sel_i(in_s1), .in_src2_sel_i(in_s2),
    .in_imm_i(in_imm), .in_pc_i(in_pc), .in_ctrl_i(in_ctrl),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_operand_a_o(out_a), .out_operand_b_o(out_b),
    .out_imm_o(out_imm), .out_pc_o(out_pc),
    .out_rd_o(out_rd), .out_rd_we_o(out_rd_we), .out_ctrl_o(out_ctrl),
    .out_illegal_o(out_illegal), .busy_o(busy)
  );

  gamma_dec_issue #(.DataWidth(32), .Embedded(0), .Bypass(0), .CtrlWidth(32)) z_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(z_in_valid), .in_ready_o(z_in_ready),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd), .in_rd_we_i(in_rd_we),
    .in_src1_sel_i(in_s1), .in_src2_sel_i(in_s2),
    .in_imm_i(in_imm), .in_pc_i(in_pc), .in_ctrl_i(in_ctrl),
    .wb_valid_i(z_wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .flush_i(flush),
    .out_valid_o(z_out_valid), .out_ready_i(out_ready),
    .out_operand_a_o(z_out_a), .out_operand_b_o(z_out_b),
    .out_imm_o(z_out_imm), .out_pc_o(z_out_pc),
    .out_rd_o(z_out_rd), .out_rd_we_o(z_out_rd_we), .out_ctrl_o(z_out_ctrl),
    .out_illegal_o(z_out_illegal), .busy_o(z_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [31:0] imm, input logic [31:0] pc);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
    in_s1 = s1; in_s2 = s2; in_imm = imm; in_pc = pc;
    in_ctrl = $urandom;
  endtask

  task automatic wb_drive(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_valid = 1'b0;
  endtask

  // Drive one instruction into the main DUT, wait (bounded) for acceptance,
  // and queue the packet it must produce.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] ea, input logic [31:0] eb, input logic eill,
                       output int nwait);
    set_in(rs1, rs2, rd, we, s1, s2, imm, pc);
    in_valid = 1'b1;
    nwait = 0;
    @(negedge clk);
    while (!in_ready && nwait < 20) begin
      nwait++;
      @(negedge clk);
    end
    if (in_ready) exp_q.push_back({ea, eb, rd, we, eill});
    else chk("issue_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare each transferred packet with the queue front.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("op_a", out_a, e[70:39]);
        chk("op_b", out_b, e[38:7]);
        chk("rd", out_rd, e[6:2]);
        chk("rd_we", out_rd_we, e[1]);
        chk("illegal", out_illegal, e[0]);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_a", out_a, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_illegal", out_illegal, 0);
    tick();

    // Basic register read and one-cycle latency
    wb_drive(5'd1, 32'h10);
    wb_drive(5'd2, 32'h20);
    issue(1, 2, 0, 0, 2'b00, 2'b00, 0, 0, 32'h10, 32'h20, 0, waits);
    chk("basic_wait", waits, 0);
    chk("latency_valid", out_valid, 1);

    // RAW on x5 resolved by forwarding in the writeback cycle
    issue(0, 0, 5, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, waits);
    set_in(5, 0, 0, 0, 2'b00, 2'b01, 32'd3, 0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("raw_stall0", in_ready, 0);
    chk("raw_busy", busy, 1);
    tick();
    @(negedge clk);
    chk("raw_stall1", in_ready, 0);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
    @(negedge clk);
    chk("raw_bypass_ready", in_ready, 1);
    if (in_ready) exp_q.push_back({32'hABCD, 32'd3, 5'd0, 1'b0, 1'b0});
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    tick();

    // Back-pressure: held packet stays put, then one transfer and next load
    out_ready = 1'b0;
    issue(1, 0, 3, 1, 2'b00, 2'b01, 32'h55, 0, 32'h10, 32'h55, 0, waits);
    set_in(2, 0, 0, 0, 2'b00, 2'b01, 32'h66, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_hold_b", out_b, 32'h55);
      chk("bp_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    if (in_ready) exp_q.push_back({32'h20, 32'h66, 5'd0, 1'b0, 1'b0});
    tick();
    in_valid = 1'b0;
    wb_drive(5'd3, 32'h33);
    tick();

    // Illegal indices on RV32E: no stall, zero operand, no scoreboard entry
    issue(20, 0, 20, 1, 2'b00, 2'b01, 32'd7, 0, 0, 32'd7, 1, waits);
    chk("illegal_wait", waits, 0);
    tick(); tick();
    chk("illegal_no_pending", busy, 0);
    wb_drive(5'd20, 32'hDEAD);
    issue(4, 20, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, waits);
    tick();

    // Flush of a held writer drops its pending bit
    out_ready = 1'b0;
    issue(0, 0, 7, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, waits);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    out_ready = 1'b1;
    issue(7, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, waits);
    chk("flush_reader_wait", waits, 0);

    // Operand selects, x0 immunity, plain forwarding
    issue(0, 0, 0, 0, 2'b10, 2'b10, 32'h9, 32'h100, 32'h100, 32'h4, 0, waits);
    issue(3, 3, 0, 0, 2'b11, 2'b11, 32'h5, 32'h200, 0, 0, 0, waits);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    issue(0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 32'h10, 0, waits);
    wb_valid = 1'b0;
    issue(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, waits);
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h77;
    issue(0, 2, 0, 0, 2'b11, 2'b00, 0, 0, 0, 32'h77, 0, waits);
    wb_valid = 1'b0;
    issue(0, 2, 0, 0, 2'b11, 2'b00, 0, 0, 0, 32'h77, 0, waits);
    tick();

    // Full throughput: one acceptance per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] r;
      r = $urandom;
      set_in(0, 0, 0, 0, 2'b01, 2'b11, r, 0);
      @(negedge clk);
      chk("tput_ready", in_ready, 1);
      if (in_ready) exp_q.push_back({r, 32'd0, 5'd0, 1'b0, 1'b0});
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();

    // No-forwarding instance: RAW fires the cycle after writeback
    set_in(0, 0, 5, 1, 2'b00, 2'b00, 0, 0);
    z_in_valid = 1'b1;
    @(negedge clk);
    chk("z_writer_ready", z_in_ready, 1);
    tick();
    set_in(5, 0, 0, 0, 2'b00, 2'b01, 32'd1, 0);
    @(negedge clk);
    chk("z_raw_stall", z_in_ready, 0);
    tick();
    z_wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
    @(negedge clk);
    chk("z_no_bypass", z_in_ready, 0);
    tick();
    z_wb_valid = 1'b0;
    @(negedge clk);
    chk("z_raw_ready", z_in_ready, 1);
    tick();
    z_in_valid = 1'b0;
    chk("z_valid", z_out_valid, 1);
    chk("z_op_a", z_out_a, 32'hABCD);

    // WAW retiring in the same cycle does not stall; x31 is legal here
    set_in(31, 0, 6, 1, 2'b00, 2'b00, 0, 0);
    z_in_valid = 1'b1;
    @(negedge clk);
    chk("z_waw_first", z_in_ready, 1);
    tick();
    chk("z_legal31", z_out_illegal, 0);
    set_in(0, 0, 6, 1, 2'b01, 2'b01, 32'd2, 0);
    z_wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    @(negedge clk);
    chk("z_waw_ready", z_in_ready, 1);
    tick();
    z_in_valid = 1'b0;
    z_wb_valid = 1'b0;
    tick();
    chk("z_waw_set_wins", z_busy, 1);
    z_wb_valid = 1'b1; wb_rd = 5'd6;
    tick();
    z_wb_valid = 1'b0;
    tick();
    chk("z_idle", z_busy, 0);

    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
